// File: rtl/serial_word_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_tx_pkg
// Brief    : Shared state encoding and sizing helpers for serial_word_tx.
// Revision : 1.0
// ============================================================================
package serial_word_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

  localparam int WORDS_CNT_W = 16;

  // One counter serves both the bit index (0..DATA_W-1) and the gap count (0..GAP_BITS-1).
  function automatic int cnt_width(input int data_w, input int gap_bits);
    int span;
    span = (data_w > gap_bits + 1) ? data_w : gap_bits + 1;
    return (span < 2) ? 1 : $clog2(span);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_word_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_tx
// Brief    : Valid/ready parallel-to-serial word transmitter with optional gap.
// Revision : 1.0
// ============================================================================
module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int   DATA_W     = 5,
  parameter int   GAP_BITS   = 0,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   LSB_FIRST  = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   bit_en,
  input  logic                   flush,
  output logic                   serial_out,
  output logic                   serial_valid,
  output logic                   busy,
  output logic                   word_done,
  output logic [WORDS_CNT_W-1:0] words_sent
);

  localparam int                 c_cnt_w    = cnt_width(DATA_W, GAP_BITS);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_W - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last = c_cnt_w'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  tx_state_t              r_state;
  tx_state_t              w_state_nxt;
  logic [DATA_W-1:0]      r_shift;
  logic [c_cnt_w-1:0]     r_cnt;
  logic                   r_serial_out;
  logic                   r_serial_valid;
  logic                   r_word_done;
  logic [WORDS_CNT_W-1:0] r_words_sent;

  logic                   w_in_ready;
  logic                   w_load;
  logic                   w_word_end;
  logic                   w_first_bit;
  logic                   w_next_bit;
  logic [DATA_W-1:0]      w_load_shift;
  logic [DATA_W-1:0]      w_shift_nxt;

  // The shift register holds only the bits not yet on serial_out.
  if (LSB_FIRST != 0) begin : g_lsb_first
    assign w_first_bit  = in_data[0];
    assign w_load_shift = {1'b0, in_data[DATA_W-1:1]};
    assign w_next_bit   = r_shift[0];
    assign w_shift_nxt  = {1'b0, r_shift[DATA_W-1:1]};
  end else begin : g_msb_first
    assign w_first_bit  = in_data[DATA_W-1];
    assign w_load_shift = {in_data[DATA_W-2:0], 1'b0};
    assign w_next_bit   = r_shift[DATA_W-1];
    assign w_shift_nxt  = {r_shift[DATA_W-2:0], 1'b0};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_load      = 1'b0;
    w_word_end  = 1'b0;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_in_ready = 1'b1;
          if (in_valid) begin
            w_load      = 1'b1;
            w_state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          if (bit_en && (r_cnt == c_last_bit)) begin
            w_word_end = 1'b1;
            if (GAP_BITS > 0) begin
              w_state_nxt = GAP;
            end else begin
              // Streaming mode: accept the next word in the last-bit cycle.
              w_in_ready = 1'b1;
              if (in_valid) begin
                w_load      = 1'b1;
                w_state_nxt = SHIFT;
              end else begin
                w_state_nxt = IDLE;
              end
            end
          end
        end
        GAP: begin
          if (bit_en && (r_cnt == c_gap_last)) begin
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift        <= '0;
      r_cnt          <= '0;
      r_serial_out   <= IDLE_LEVEL;
      r_serial_valid <= 1'b0;
      r_word_done    <= 1'b0;
      r_words_sent   <= '0;
    end else begin
      r_word_done <= w_word_end;
      if (w_word_end) begin
        r_words_sent <= r_words_sent + 1'b1;
      end
      if (flush) begin
        r_cnt          <= '0;
        r_serial_out   <= IDLE_LEVEL;
        r_serial_valid <= 1'b0;
      end else if (w_load) begin
        r_shift        <= w_load_shift;
        r_cnt          <= '0;
        r_serial_out   <= w_first_bit;
        r_serial_valid <= 1'b1;
      end else if (w_word_end) begin
        r_cnt          <= '0;
        r_serial_out   <= IDLE_LEVEL;
        r_serial_valid <= 1'b0;
      end else if (bit_en && (r_state == SHIFT)) begin
        r_shift      <= w_shift_nxt;
        r_cnt        <= r_cnt + 1'b1;
        r_serial_out <= w_next_bit;
      end else if (bit_en && (r_state == GAP)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign serial_out   = r_serial_out;
  assign serial_valid = r_serial_valid;
  assign busy         = (r_state != IDLE);
  assign word_done    = r_word_done;
  assign words_sent   = r_words_sent;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_word_tx
// Brief    : Directed self-checking bench for serial_word_tx (streaming and gap builds).
// Revision : 1.0
// ============================================================================
module tb_serial_word_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  int          checks   = 0;
  int          failures = 0;

  // u0: DATA_W=5, no gap, LSB first, idle low
  logic [4:0]  in_data0;
  logic        in_valid0, in_ready0, bit_en0, flush0;
  logic        serial_out0, serial_valid0, busy0, word_done0;
  logic [15:0] words_sent0;

  // u2: DATA_W=5, two-bit gap, MSB first, idle high
  logic [4:0]  in_data2;
  logic        in_valid2, in_ready2, bit_en2, flush2;
  logic        serial_out2, serial_valid2, busy2, word_done2;
  logic [15:0] words_sent2;

  serial_word_tx #(.DATA_W(5), .GAP_BITS(0), .IDLE_LEVEL(1'b0), .LSB_FIRST(1)) u0 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .bit_en(bit_en0), .flush(flush0), .serial_out(serial_out0),
    .serial_valid(serial_valid0), .busy(busy0), .word_done(word_done0),
    .words_sent(words_sent0)
  );

  serial_word_tx #(.DATA_W(5), .GAP_BITS(2), .IDLE_LEVEL(1'b1), .LSB_FIRST(0)) u2 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .bit_en(bit_en2), .flush(flush2), .serial_out(serial_out2),
    .serial_valid(serial_valid2), .busy(busy2), .word_done(word_done2),
    .words_sent(words_sent2)
  );

  task automatic test_reset;
    reset_n = 1'b0;
    in_data0 = '0; in_valid0 = 1'b0; bit_en0 = 1'b1; flush0 = 1'b0;
    in_data2 = '0; in_valid2 = 1'b0; bit_en2 = 1'b1; flush2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (serial_out0 !== 1'b0) begin failures++; $display("FAIL reset_out0: got %b want 0", serial_out0); end
    checks++; if (serial_valid0 !== 1'b0) begin failures++; $display("FAIL reset_valid0: got %b want 0", serial_valid0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy0: got %b want 0", busy0); end
    checks++; if (word_done0 !== 1'b0) begin failures++; $display("FAIL reset_done0: got %b want 0", word_done0); end
    checks++; if (words_sent0 !== 16'd0) begin failures++; $display("FAIL reset_count0: got %0d want 0", words_sent0); end
    checks++; if (serial_out2 !== 1'b1) begin failures++; $display("FAIL reset_out2: got %b want 1", serial_out2); end
    checks++; if (serial_valid2 !== 1'b0) begin failures++; $display("FAIL reset_valid2: got %b want 0", serial_valid2); end
    reset_n = 1'b1;
  endtask

  task automatic test_single;
    logic [4:0] w;
    w = 5'b10110;
    @(negedge clk);
    in_data0 = w; in_valid0 = 1'b1; #1;
    checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL single_ready_idle: got %b want 1", in_ready0); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (serial_valid0 !== 1'b1) begin failures++; $display("FAIL single_valid%0d: got %b want 1", k, serial_valid0); end
      checks++; if (serial_out0 !== w[k]) begin failures++; $display("FAIL single_bit%0d: got %b want %b", k, serial_out0, w[k]); end
      if (k == 0) begin in_valid0 = 1'b0; in_data0 = 5'b01001; end
      #1;
      checks++; if (in_ready0 !== (k == 4)) begin failures++; $display("FAIL single_ready%0d: got %b want %b", k, in_ready0, (k == 4)); end
    end
    @(negedge clk);
    checks++; if (word_done0 !== 1'b1) begin failures++; $display("FAIL single_done: got %b want 1", word_done0); end
    checks++; if (words_sent0 !== 16'd1) begin failures++; $display("FAIL single_count: got %0d want 1", words_sent0); end
    checks++; if (serial_valid0 !== 1'b0) begin failures++; $display("FAIL single_valid_end: got %b want 0", serial_valid0); end
    checks++; if (serial_out0 !== 1'b0) begin failures++; $display("FAIL single_idle_level: got %b want 0", serial_out0); end
    @(negedge clk);
    checks++; if (word_done0 !== 1'b0) begin failures++; $display("FAIL single_done_pulse: got %b want 0", word_done0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL single_busy_end: got %b want 0", busy0); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] stream;
    stream = {5'b11100, 5'b00011};
    @(negedge clk);
    in_data0 = 5'b00011; in_valid0 = 1'b1; #1;
    checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL b2b_ready_idle: got %b want 1", in_ready0); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++; if (serial_valid0 !== 1'b1) begin failures++; $display("FAIL b2b_valid%0d: got %b want 1", k, serial_valid0); end
      checks++; if (serial_out0 !== stream[k]) begin failures++; $display("FAIL b2b_bit%0d: got %b want %b", k, serial_out0, stream[k]); end
      if (k == 5) begin
        checks++; if (word_done0 !== 1'b1) begin failures++; $display("FAIL b2b_done_first: got %b want 1", word_done0); end
        checks++; if (words_sent0 !== 16'd2) begin failures++; $display("FAIL b2b_count_first: got %0d want 2", words_sent0); end
      end
      if (k == 0) in_data0 = 5'b11100;
      if (k == 5) in_valid0 = 1'b0;
      #1;
      checks++; if (in_ready0 !== (k == 4 || k == 9)) begin failures++; $display("FAIL b2b_ready%0d: got %b want %b", k, in_ready0, (k == 4 || k == 9)); end
    end
    @(negedge clk);
    checks++; if (word_done0 !== 1'b1) begin failures++; $display("FAIL b2b_done_second: got %b want 1", word_done0); end
    checks++; if (words_sent0 !== 16'd3) begin failures++; $display("FAIL b2b_count: got %0d want 3", words_sent0); end
    checks++; if (serial_valid0 !== 1'b0) begin failures++; $display("FAIL b2b_valid_end: got %b want 0", serial_valid0); end
  endtask

  task automatic test_slow_bit_en;
    logic [4:0] w;
    w = 5'b01001;
    @(negedge clk);
    in_data0 = w; in_valid0 = 1'b1; bit_en0 = 1'b0; #1;
    checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL slow_ready_idle: got %b want 1", in_ready0); end
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      checks++; if (serial_out0 !== w[j/3]) begin failures++; $display("FAIL slow_bit_cycle%0d: got %b want %b", j, serial_out0, w[j/3]); end
      checks++; if (word_done0 !== 1'b0) begin failures++; $display("FAIL slow_early_done%0d: got %b want 0", j, word_done0); end
      if (j == 0) in_valid0 = 1'b0;
      bit_en0 = ((j % 3) == 2);
      #1;
      checks++; if (in_ready0 !== (j == 14)) begin failures++; $display("FAIL slow_ready%0d: got %b want %b", j, in_ready0, (j == 14)); end
    end
    @(negedge clk);
    bit_en0 = 1'b1;
    checks++; if (word_done0 !== 1'b1) begin failures++; $display("FAIL slow_done: got %b want 1", word_done0); end
    checks++; if (words_sent0 !== 16'd4) begin failures++; $display("FAIL slow_count: got %0d want 4", words_sent0); end
  endtask

  task automatic test_gap;
    logic [4:0] a, b;
    logic       e_out, e_valid, e_rdy, e_busy;
    a = 5'b10011; b = 5'b01101;
    @(negedge clk);
    in_data2 = a; in_valid2 = 1'b1; #1;
    checks++; if (in_ready2 !== 1'b1) begin failures++; $display("FAIL gap_ready_idle: got %b want 1", in_ready2); end
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k < 5) begin
        e_out = a[4-k]; e_valid = 1'b1; e_rdy = 1'b0; e_busy = 1'b1;
      end else if (k < 7) begin
        e_out = 1'b1; e_valid = 1'b0; e_rdy = 1'b0; e_busy = 1'b1;
      end else if (k == 7) begin
        e_out = 1'b1; e_valid = 1'b0; e_rdy = 1'b1; e_busy = 1'b0;
      end else if (k < 13) begin
        e_out = b[12-k]; e_valid = 1'b1; e_rdy = 1'b0; e_busy = 1'b1;
      end else begin
        e_out = 1'b1; e_valid = 1'b0; e_rdy = 1'b0; e_busy = 1'b1;
      end
      checks++; if (serial_out2 !== e_out) begin failures++; $display("FAIL gap_out%0d: got %b want %b", k, serial_out2, e_out); end
      checks++; if (serial_valid2 !== e_valid) begin failures++; $display("FAIL gap_valid%0d: got %b want %b", k, serial_valid2, e_valid); end
      checks++; if (busy2 !== e_busy) begin failures++; $display("FAIL gap_busy%0d: got %b want %b", k, busy2, e_busy); end
      checks++; if (word_done2 !== (k == 5 || k == 13)) begin failures++; $display("FAIL gap_done%0d: got %b want %b", k, word_done2, (k == 5 || k == 13)); end
      if (k == 0) in_data2 = b;
      if (k == 8) in_valid2 = 1'b0;
      #1;
      checks++; if (in_ready2 !== e_rdy) begin failures++; $display("FAIL gap_ready%0d: got %b want %b", k, in_ready2, e_rdy); end
    end
    checks++; if (words_sent2 !== 16'd2) begin failures++; $display("FAIL gap_count: got %0d want 2", words_sent2); end
  endtask

  task automatic test_flush_reset;
    logic [4:0] w1, w2, w3;
    w1 = 5'b11010; w2 = 5'b00101; w3 = 5'b01110;
    @(negedge clk);
    in_data0 = w1; in_valid0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (serial_out0 !== w1[k]) begin failures++; $display("FAIL flush_pre_bit%0d: got %b want %b", k, serial_out0, w1[k]); end
      in_valid0 = 1'b0;
    end
    flush0 = 1'b1; in_valid0 = 1'b1; in_data0 = w2; #1;
    checks++; if (in_ready0 !== 1'b0) begin failures++; $display("FAIL flush_ready: got %b want 0", in_ready0); end
    @(negedge clk);
    checks++; if (serial_out0 !== 1'b0) begin failures++; $display("FAIL flush_out: got %b want 0", serial_out0); end
    checks++; if (serial_valid0 !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b want 0", serial_valid0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL flush_busy: got %b want 0", busy0); end
    checks++; if (word_done0 !== 1'b0) begin failures++; $display("FAIL flush_done: got %b want 0", word_done0); end
    checks++; if (words_sent0 !== 16'd4) begin failures++; $display("FAIL flush_count: got %0d want 4", words_sent0); end
    flush0 = 1'b0; #1;
    checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL flush_ready_after: got %b want 1", in_ready0); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (serial_out0 !== w2[k]) begin failures++; $display("FAIL rst_pre_bit%0d: got %b want %b", k, serial_out0, w2[k]); end
      in_valid0 = 1'b0;
    end
    reset_n = 1'b0; #1;
    checks++; if (serial_out0 !== 1'b0) begin failures++; $display("FAIL rst_out: got %b want 0", serial_out0); end
    checks++; if (serial_valid0 !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", serial_valid0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy0); end
    checks++; if (words_sent0 !== 16'd0) begin failures++; $display("FAIL rst_count: got %0d want 0", words_sent0); end
    @(negedge clk);
    checks++; if (word_done0 !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", word_done0); end
    reset_n = 1'b1;
    @(negedge clk);
    in_data0 = w3; in_valid0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (serial_out0 !== w3[k]) begin failures++; $display("FAIL post_rst_bit%0d: got %b want %b", k, serial_out0, w3[k]); end
      checks++; if (word_done0 !== 1'b0) begin failures++; $display("FAIL post_rst_early_done%0d: got %b want 0", k, word_done0); end
      in_valid0 = 1'b0;
    end
    @(negedge clk);
    checks++; if (word_done0 !== 1'b1) begin failures++; $display("FAIL post_rst_done: got %b want 1", word_done0); end
    checks++; if (words_sent0 !== 16'd1) begin failures++; $display("FAIL post_rst_count: got %0d want 1", words_sent0); end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    force u0.r_words_sent = 16'hFFFF;
    #1;
    release u0.r_words_sent;
    #1;
    checks++; if (words_sent0 !== 16'hFFFF) begin failures++; $display("FAIL wrap_preset: got %h want ffff", words_sent0); end
    @(negedge clk);
    in_data0 = 5'b10101; in_valid0 = 1'b1;
    repeat (5) begin
      @(negedge clk);
      in_valid0 = 1'b0;
    end
    checks++; if (words_sent0 !== 16'hFFFF) begin failures++; $display("FAIL wrap_hold: got %h want ffff", words_sent0); end
    @(negedge clk);
    checks++; if (word_done0 !== 1'b1) begin failures++; $display("FAIL wrap_done: got %b want 1", word_done0); end
    checks++; if (words_sent0 !== 16'h0000) begin failures++; $display("FAIL wrap_count: got %h want 0000", words_sent0); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_slow_bit_en();
    test_gap();
    test_flush_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-to-serial transmitter that sits directly upstream of the serial pattern detector and drives its serial_in.
- Accepts DATA_W-bit words over a valid/ready handshake and shifts them out one bit per bit_en strobe, LSB first.
- With LSB-first order, after DATA_W shifts the detector's 5-bit shift register holds exactly the transmitted word.
- Provides an optional inter-word gap, flush, a completion pulse and a sent-word counter.

Parameters:
- DATA_W, 5, word width in bits (>=2).
- GAP_BITS, 0, number of idle bit-times inserted after each word (0 = back-to-back streaming allowed).
- IDLE_LEVEL, 1'b0, serial_out level when no data bit is driven.
- LSB_FIRST, 1, 1 = bit 0 first; 0 = bit DATA_W-1 first.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- bit_en  input  1  bit-rate strobe; tie to 1 for one bit per clk.
- flush  input  1  synchronous abort of the current word or gap.
- serial_out  output  1  serial data, registered; connects to the detector's serial_in.
- serial_valid  output  1  high while serial_out carries a data bit.
- busy  output  1  state != IDLE.
- word_done  output  1  one-cycle pulse after the last bit of a word completes.
- words_sent  output  16  count of fully transmitted words; wraps.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; serial_out=IDLE_LEVEL; serial_valid=0; busy=0; word_done=0; words_sent=0.
  - Shift register and bit counter are cleared.
  - Reset mid-word discards the word with no word_done.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge t: load shift register, bit counter=0, go to SHIFT.
  - From cycle t+1: serial_out = first bit, serial_valid=1.
- SHIFT:
  - The current bit is held on serial_out until a cycle with bit_en=1; at that edge the next bit is presented.
  - On bit_en with bit counter==DATA_W-1, the word is complete:
    - words_sent increments; word_done=1 for the next cycle only.
    - If GAP_BITS>0: go to GAP, serial_out=IDLE_LEVEL, serial_valid=0.
    - If GAP_BITS==0: in_ready=1 combinationally in that last-bit cycle. If in_valid is high, load the new word and present its bit 0 at the next cycle with no idle bit; otherwise go to IDLE.
- GAP:
  - Counts GAP_BITS bit_en strobes with serial_out=IDLE_LEVEL, then goes to IDLE.
  - in_ready=0 throughout.
- in_ready is 0 in every other case. in_data is sampled only on handshake, so later changes do not affect the word in flight.
- flush (highest priority after reset):
  - At the next edge: state=IDLE, serial_out=IDLE_LEVEL, serial_valid=0.
  - No word_done and no words_sent increment.
  - in_ready is forced 0 during a flush cycle, so no handshake occurs.
- bit_en outside SHIFT/GAP has no effect.
- Latency with bit_en=1: handshake at edge t -> bits on cycles t+1..t+DATA_W -> word_done at t+DATA_W+1.
- words_sent wraps from 16'hFFFF to 0.
- busy = (state != IDLE), registered with the state.

Decomposition:
- Shared package:
  - typedef enum for tx_state_t {IDLE, SHIFT, GAP}.
  - Localparam for the counter width ($clog2 of max(DATA_W, GAP_BITS+1)).
  - WORDS_CNT_W = 16.
- No sub-module: FSM, shift register and counters sit in one module.

Test Plan:
- DATA_W=5, bit_en=1, send 5'b10110: serial_out = 0,1,1,0,1 on cycles t+1..t+5. The downstream detector loaded with pattern 5'b10110 asserts pattern_match at t+6, word_done=1 at t+6, words_sent=1.
- Back-to-back, GAP_BITS=0, in_valid held with 5'b00011 then 5'b11100: 10 contiguous serial_valid cycles; in_ready high only at t (IDLE) and t+5 (last bit); words_sent=2.
- bit_en every 3rd cycle, word 5'b01001: each bit held 3 cycles; word_done 15 cycles after the first bit appears.
- GAP_BITS=2, two queued words: 2 bit-times of IDLE_LEVEL with serial_valid=0 between them; in_ready=0 during GAP.
- Flush on bit 2, then reset_n pulse on bit 3 of the next word: IDLE_LEVEL on the next cycle each time; no word_done; words_sent unchanged; next word transmits correctly.
- Counter wrap: force words_sent to 16'hFFFF, send one word -> words_sent=0.
